// File: rtl/fix2flt_engine.sv
// Converts 16-bit two's-complement words in data memory to IEEE-754 half precision.
// The result is rounded to nearest even. The block is a byte-wide bus master with a start/done handshake.
module fix2flt_engine #(
    parameter int AW        = 8,
    parameter int SRC_BASE  = 0,
    parameter int DST_BASE  = 30,
    parameter int NUM_WORDS = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          done,
    output logic [AW-1:0] mem_addr,
    output logic          mem_read,
    output logic          mem_write,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata,
    output logic [2:0]    dbg_state
);

    // Memory handshake: mem_read samples mem_rdata combinationally in the same cycle.
    // mem_write commits mem_wdata at mem_addr on the next rising clk.
    // The two strobes are never asserted together.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD_HI = 3'd1,
        S_RD_LO = 3'd2,
        S_NORM  = 3'd3,
        S_ROUND = 3'd4,
        S_WR_HI = 3'd5,
        S_WR_LO = 3'd6,
        S_FIN   = 3'd7
    } state_t;

    state_t        state_q, state_d;
    logic          start_q;
    logic [6:0]    idx_q, idx_d;
    logic [7:0]    msb_q, msb_d;
    logic [15:0]   mag_q, mag_d;
    logic [3:0]    k_q, k_d;
    logic          sign_q, sign_d;
    logic [15:0]   result_q, result_d;

    logic          start_edge;
    logic [15:0]   x_full;
    logic [15:0]   mag_abs;
    logic [4:0]    exp_base;
    logic          round_up;
    logic [14:0]   rounded;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic          last_word;

    assign start_edge = start & ~start_q;
    assign x_full     = {msb_q, mem_rdata};
    assign mag_abs    = x_full[15] ? (~x_full + 16'd1) : x_full;
    assign exp_base   = 5'd30 - {1'b0, k_q};
    assign round_up   = mag_q[4] & ((|mag_q[3:0]) | mag_q[5]);
    // A mantissa carry-out ripples straight into the exponent field.
    assign rounded    = {exp_base, mag_q[14:5]} + {14'd0, round_up};
    assign src_addr   = AW'(SRC_BASE) + AW'({idx_q, 1'b0});
    assign dst_addr   = AW'(DST_BASE) + AW'({idx_q, 1'b0});
    assign last_word  = (idx_q == 7'(NUM_WORDS - 1));

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        msb_d     = msb_q;
        mag_d     = mag_q;
        k_d       = k_q;
        sign_d    = sign_q;
        result_d  = result_q;
        mem_addr  = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_wdata = 8'd0;
        case (state_q)
            S_IDLE, S_FIN: begin
                if (start_edge) begin
                    idx_d   = 7'd0;
                    state_d = S_RD_HI;
                end
            end
            S_RD_HI: begin
                mem_read = 1'b1;
                mem_addr = src_addr;
                msb_d    = mem_rdata;
                state_d  = S_RD_LO;
            end
            S_RD_LO: begin
                mem_read = 1'b1;
                mem_addr = src_addr + AW'(1);
                sign_d   = x_full[15];
                mag_d    = mag_abs;
                k_d      = 4'd0;
                if (x_full == 16'd0) begin
                    result_d = 16'd0;
                    state_d  = S_WR_HI;
                end else begin
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                if (!mag_q[15]) begin
                    mag_d = mag_q << 1;
                    k_d   = k_q + 4'd1;
                end else begin
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                result_d = {sign_q, rounded};
                state_d  = S_WR_HI;
            end
            S_WR_HI: begin
                mem_write = 1'b1;
                mem_addr  = dst_addr;
                mem_wdata = result_q[15:8];
                state_d   = S_WR_LO;
            end
            S_WR_LO: begin
                mem_write = 1'b1;
                mem_addr  = dst_addr + AW'(1);
                mem_wdata = result_q[7:0];
                idx_d     = idx_q + 7'd1;
                state_d   = last_word ? S_FIN : S_RD_HI;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            start_q  <= 1'b0;
            idx_q    <= 7'd0;
            msb_q    <= 8'd0;
            mag_q    <= 16'd0;
            k_q      <= 4'd0;
            sign_q   <= 1'b0;
            result_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            start_q  <= start;
            idx_q    <= idx_d;
            msb_q    <= msb_d;
            mag_q    <= mag_d;
            k_q      <= k_d;
            sign_q   <= sign_d;
            result_q <= result_d;
        end
    end

    assign done      = (state_q == S_FIN);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fix2flt_engine.sv
// Bench for fix2flt_engine: a byte memory model plus an arithmetic int16->half reference.
// Each task drives a scenario and checks memory contents, latency and strobes against that reference.
module tb_fix2flt_engine;

    localparam int NW  = 15;
    localparam int SRC = 0;
    localparam int DST = 30;
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_NORM = 3'd3;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       done;
    logic [7:0] mem_addr;
    logic       mem_read;
    logic       mem_write;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic [2:0] dbg_state;

    logic [7:0]  mem     [256];
    logic [7:0]  exp_mem [256];
    logic        tb_we = 1'b0;
    logic [7:0]  tb_waddr;
    logic [7:0]  tb_wdata;

    logic [15:0] words [NW];
    logic [15:0] exp_q [$];
    int          lat_q [$];
    int          exp_lat;
    int          both_hi;
    int          errors = 0;
    int          checks = 0;

    fix2flt_engine #(.AW(8), .SRC_BASE(SRC), .DST_BASE(DST), .NUM_WORDS(NW)) dut (
        .clk(clk), .reset(reset), .start(start), .done(done),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_wdata;
        else if (tb_we) mem[tb_waddr] <= tb_wdata;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: locate the leading one arithmetically and round the dropped bits to nearest even.
    task automatic ref_half(input logic [15:0] x, output logic [15:0] r, output int lat);
        int v, e, shift, q, rem, half, k;
        logic s;
        if (x == 16'd0) begin
            r   = 16'd0;
            lat = 4;
            return;
        end
        s = x[15];
        v = s ? (65536 - int'(x)) : int'(x);
        e = 0;
        while ((1 << (e + 1)) <= v) e++;
        k = 15 - e;
        if (e <= 10) begin
            q = v << (10 - e);
        end else begin
            shift = e - 10;
            q     = v >> shift;
            rem   = v - (q << shift);
            half  = 1 << (shift - 1);
            if (rem > half || (rem == half && (q % 2) == 1)) q++;
            if (q == 2048) begin
                q = 1024;
                e++;
            end
        end
        r   = {s, 5'(e + 15), 10'(q - 1024)};
        lat = k + 6;
    endtask

    task automatic poke(input int a, input logic [7:0] d);
        tb_waddr   = 8'(a);
        tb_wdata   = d;
        tb_we      = 1'b1;
        exp_mem[a] = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic load_words();
        logic [15:0] r;
        int          l;
        exp_q.delete();
        lat_q.delete();
        exp_lat = 0;
        for (int i = 0; i < NW; i++) begin
            ref_half(words[i], r, l);
            exp_q.push_back(r);
            lat_q.push_back(l);
            exp_lat += l;
            poke(SRC + 2 * i,     words[i][15:8]);
            poke(SRC + 2 * i + 1, words[i][7:0]);
            poke(DST + 2 * i,     8'($urandom_range(0, 255)));
            poke(DST + 2 * i + 1, 8'($urandom_range(0, 255)));
        end
    endtask

    function automatic logic [15:0] rand_word();
        logic [15:0] v;
        v = 16'($urandom_range(0, 65535)) >> $urandom_range(0, 15);
        if ($urandom_range(0, 1) == 1) v = -v;
        return v;
    endfunction

    // Enter at a negedge with start low for at least one clock; returns clocks from the start edge to done.
    task automatic run_and_wait(input string name, input bit toggle, output int cycles);
        cycles  = 0;
        both_hi = 0;
        start   = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s done_after_edge: got %b want 0", name, done);
        end
        while (cycles < 2000) begin
            @(posedge clk);
            #1;
            cycles++;
            if (mem_read && mem_write) both_hi++;
            if (toggle && cycles == 10) start = 1'b0;
            if (toggle && cycles == 12) start = 1'b1;
            if (done === 1'b1) break;
        end
        if (cycles >= 2000) $display("FAIL %s timeout: done not seen in %0d clocks", name, cycles);
        @(negedge clk);
    endtask

    task automatic check_results(input string name, input int cycles);
        logic [15:0] got;
        int          bad;
        checks++;
        if (cycles !== exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, cycles, exp_lat);
        end
        checks++;
        if (both_hi != 0) begin
            errors++;
            $display("FAIL %s strobe_overlap: got %0d cycles want 0", name, both_hi);
        end
        for (int i = 0; i < NW; i++) begin
            got = {mem[DST + 2 * i], mem[DST + 2 * i + 1]};
            checks++;
            if (got !== exp_q[i]) begin
                errors++;
                $display("FAIL %s word%0d x=%h: got %h want %h", name, i, words[i], got, exp_q[i]);
            end
        end
        bad = 0;
        for (int b = 0; b < 256; b++)
            if ((b < DST || b >= DST + 2 * NW) && mem[b] !== exp_mem[b]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s untouched: got %0d changed bytes want 0", name, bad);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0 || mem_addr !== 8'd0 || mem_wdata !== 8'd0) begin
            errors++;
            $display("FAIL reset_bus: got rd=%b wr=%b addr=%h wdata=%h want 0 0 00 00",
                     mem_read, mem_write, mem_addr, mem_wdata);
        end
        checks++;
        if (done !== 1'b0 || dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_state: got done=%b state=%0d want 0 %0d", done, dbg_state, ST_IDLE);
        end
        reset = 1'b0;
        @(negedge clk);
        for (int b = 0; b < 256; b++) poke(b, 8'($urandom_range(0, 255)));
    endtask

    task automatic test_directed();
        logic [15:0] known [8];
        logic [15:0] got;
        int          cyc;
        known = '{16'h3C00, 16'hBC00, 16'h0000, 16'hF800, 16'h7800, 16'h6800, 16'h6802, 16'h6802};
        words[0] = 16'h0001; words[1] = 16'hFFFF; words[2] = 16'h0000; words[3] = 16'h8000;
        words[4] = 16'h7FFF; words[5] = 16'h0801; words[6] = 16'h0803; words[7] = 16'h0805;
        for (int i = 8; i < NW; i++) words[i] = rand_word();
        load_words();
        run_and_wait("directed", 1'b0, cyc);
        start = 1'b0;
        check_results("directed", cyc);
        for (int i = 0; i < 8; i++) begin
            got = {mem[DST + 2 * i], mem[DST + 2 * i + 1]};
            checks++;
            if (got !== known[i]) begin
                errors++;
                $display("FAIL directed_const%0d x=%h: got %h want %h", i, words[i], got, known[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_zero_words();
        int cyc;
        for (int i = 0; i < NW; i++) words[i] = 16'h0000;
        load_words();
        run_and_wait("zeros", 1'b0, cyc);
        start = 1'b0;
        check_results("zeros", cyc);
        checks++;
        if (cyc !== 4 * NW) begin
            errors++;
            $display("FAIL zeros_latency_const: got %0d want %0d", cyc, 4 * NW);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        int cyc;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < NW; i++) words[i] = rand_word();
            load_words();
            run_and_wait("random", 1'b0, cyc);
            start = 1'b0;
            check_results("random", cyc);
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_run();
        int          cyc, pre;
        logic [15:0] got;
        for (int i = 0; i < NW; i++) words[i] = rand_word();
        words[0] = 16'h1234; words[1] = 16'hC001; words[2] = 16'h0040; words[3] = 16'h0001;
        load_words();
        pre   = lat_q[0] + lat_q[1] + lat_q[2];
        start = 1'b1;
        @(posedge clk);
        repeat (pre + 8) @(posedge clk);
        #1;
        checks++;
        if (dbg_state !== ST_NORM) begin
            errors++;
            $display("FAIL midrun_in_norm: got state %0d want %0d", dbg_state, ST_NORM);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (done !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0 || dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL midrun_abort: got done=%b rd=%b wr=%b state=%0d want 0 0 0 %0d",
                     done, mem_read, mem_write, dbg_state, ST_IDLE);
        end
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        for (int i = 0; i < NW; i++) begin
            got = {mem[DST + 2 * i], mem[DST + 2 * i + 1]};
            checks++;
            if (i < 3 && got !== exp_q[i]) begin
                errors++;
                $display("FAIL midrun_written%0d: got %h want %h", i, got, exp_q[i]);
            end else if (i >= 3 && got !== {exp_mem[DST + 2 * i], exp_mem[DST + 2 * i + 1]}) begin
                errors++;
                $display("FAIL midrun_unwritten%0d: got %h want %h", i, got,
                         {exp_mem[DST + 2 * i], exp_mem[DST + 2 * i + 1]});
            end
        end
        @(negedge clk);
        run_and_wait("after_reset", 1'b0, cyc);
        start = 1'b0;
        check_results("after_reset", cyc);
        @(negedge clk);
    endtask

    task automatic test_start_held();
        int cyc, strobes, not_done;
        for (int i = 0; i < NW; i++) words[i] = rand_word();
        load_words();
        run_and_wait("held_toggle", 1'b1, cyc);
        check_results("held_toggle", cyc);
        strobes  = 0;
        not_done = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (mem_read || mem_write) strobes++;
            if (done !== 1'b1) not_done++;
        end
        checks++;
        if (strobes != 0 || not_done != 0) begin
            errors++;
            $display("FAIL held_no_retrigger: got strobes=%0d not_done=%0d want 0 0", strobes, not_done);
        end
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < NW; i++) words[i] = rand_word();
        load_words();
        run_and_wait("rerun_from_fin", 1'b0, cyc);
        start = 1'b0;
        check_results("rerun_from_fin", cyc);
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_zero_words();
        test_random();
        test_reset_mid_run();
        test_start_held();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
